mouse_ctrl_sequencer: RTL and testbench

Controller that owns the PS/2 transceiver (`ps2_rxtx`) for the falling-sand mouse path. It brings the mouse up with the sequence reset, self-test check, ID read, set sample rate and enable streaming. Each step has ACK/NAK checking, a timeout and bounded retries. Once streaming, it frames 3-byte movement packets into signed deltas and buttons for the cursor/brush logic.

---
 rtl/mouse_pkg.sv | 33 +++
 rtl/mouse_packet_assembler.sv | 59 +++++
 rtl/mouse_ctrl_sequencer.sv | 158 +++++++++++++++
 tb/tb_mouse_ctrl_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// PS/2 command/response codes and the bring-up sequencer state encoding
// shared by the mouse controller files.
package mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_NAK      = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_ERR  = 8'hFC;

    typedef enum logic [2:0] {
        SEND     = 3'd0,
        WAIT_TX  = 3'd1,
        WAIT_ACK = 3'd2,
        WAIT_BAT = 3'd3,
        WAIT_ID  = 3'd4,
        STREAM   = 3'd5,
        ERROR    = 3'd6
    } seq_state_e;

    // Bring-up command list: reset, set-rate, rate argument, enable streaming.
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [7:0] rate);
        case (idx)
            2'd0:    return CMD_RESET;
            2'd1:    return CMD_SET_RATE;
            2'd2:    return rate;
            default: return CMD_ENABLE;
        endcase
    endfunction

endpackage

// File: rtl/mouse_packet_assembler.sv
// Frames 3-byte PS/2 movement packets into signed deltas and buttons while
// the sequencer is streaming; a resync pulse drops any partial packet.
module mouse_packet_assembler (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable,
    input  logic              resync,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              pkt_valid,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic [2:0]        btn
);

    logic [1:0] byte_idx;
    logic [7:0] b0;
    logic [7:0] b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the held packet bytes are reset too, so a reset mid-packet leaves nothing stale behind.
            byte_idx  <= 2'd0;
            b0        <= 8'h00;
            b1        <= 8'h00;
            pkt_valid <= 1'b0;
            dx        <= 9'sd0;
            dy        <= 9'sd0;
            btn       <= 3'b000;
        end else begin
            pkt_valid <= 1'b0;
            if (!enable || resync) begin
                byte_idx <= 2'd0;
            end else if (rx_done) begin
                case (byte_idx)
                    2'd0: begin
                        // Bit 3 is always set in a header byte; anything else is noise.
                        if (rx_data[3]) begin
                            b0       <= rx_data;
                            byte_idx <= 2'd1;
                        end
                    end
                    2'd1: begin
                        b1       <= rx_data;
                        byte_idx <= 2'd2;
                    end
                    default: begin
                        dx        <= b0[6] ? 9'sd0 : $signed({b0[4], b1});
                        dy        <= b0[7] ? 9'sd0 : $signed({b0[5], rx_data});
                        btn       <= b0[2:0];
                        pkt_valid <= 1'b1;
                        byte_idx  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/mouse_ctrl_sequencer.sv
// Owns the PS/2 transceiver for the mouse: reset/self-test/ID/rate/enable
// bring-up with ACK checking, timeouts and bounded retries, then packet streaming.
module mouse_ctrl_sequencer
    import mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 60_000_000,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              tx_en_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_done_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_done_i,
    output logic              stream_o,
    output logic              error_o,
    output logic              pkt_valid_o,
    output logic signed [8:0] dx_o,
    output logic signed [8:0] dy_o,
    output logic [2:0]        btn_o,
    output logic [2:0]        state_o
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    seq_state_e         state, state_next;
    logic [1:0]         cmd_idx, cmd_idx_next;
    logic [RETRY_W-1:0] retry_cnt, retry_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               timer_expired;
    logic               waiting;
    logic               fail;
    logic               fail_full;
    logic               resync;

    assign timer_expired = (timer == TIMER_LAST);
    assign waiting       = state inside {WAIT_TX, WAIT_ACK, WAIT_BAT, WAIT_ID, STREAM};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next   = state;
        cmd_idx_next = cmd_idx;
        retry_next   = retry_cnt;
        fail         = 1'b0;
        fail_full    = 1'b1;

        unique case (state)
            SEND: state_next = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_i)          state_next = WAIT_ACK;
                else if (timer_expired) fail = 1'b1;
            end
            WAIT_ACK: begin
                if (rx_done_i) begin
                    if (rx_data_i == RSP_ACK) begin
                        case (cmd_idx)
                            2'd0: state_next = WAIT_BAT;
                            2'd3: begin
                                state_next = STREAM;
                                retry_next = '0;
                            end
                            default: begin
                                cmd_idx_next = cmd_idx + 2'd1;
                                state_next   = SEND;
                            end
                        endcase
                    end else begin
                        fail      = 1'b1;
                        fail_full = (rx_data_i != RSP_NAK);
                    end
                end else if (timer_expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (rx_done_i) begin
                    if (rx_data_i == RSP_BAT_OK) state_next = WAIT_ID;
                    else                         fail = 1'b1;
                end else if (timer_expired) begin
                    fail = 1'b1;
                end
            end
            WAIT_ID: begin
                if (rx_done_i) begin
                    cmd_idx_next = 2'd1;
                    state_next   = SEND;
                end else if (timer_expired) begin
                    fail = 1'b1;
                end
            end
            STREAM, ERROR: begin
                if (start_i) begin
                    state_next   = SEND;
                    cmd_idx_next = 2'd0;
                    retry_next   = '0;
                end
            end
            default: state_next = SEND;
        endcase

        // A NAK resends the same byte; every other failure restarts from reset.
        if (fail) begin
            if (retry_cnt == RETRY_MAX) begin
                state_next = ERROR;
            end else begin
                retry_next = retry_cnt + RETRY_W'(1);
                state_next = SEND;
                if (fail_full) cmd_idx_next = 2'd0;
            end
        end

        if (state_next != state || rx_done_i || timer_expired || !waiting) timer_next = '0;
        else                                                               timer_next = timer + TIMER_W'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= SEND;
            cmd_idx   <= 2'd0;
            retry_cnt <= '0;
            timer     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state     <= state_next;
            cmd_idx   <= cmd_idx_next;
            retry_cnt <= retry_next;
            timer     <= timer_next;
        end
    end

    // SEND is the reset state, so the strobe is masked while reset is held.
    assign tx_en_o   = (state == SEND) && !reset_i;
    assign tx_data_o = cmd_byte(cmd_idx, SAMPLE_RATE);
    assign stream_o  = (state == STREAM);
    assign error_o   = (state == ERROR);
    assign state_o   = state;
    assign resync    = stream_o && timer_expired && !rx_done_i;

    mouse_packet_assembler u_assembler (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enable    (stream_o),
        .resync    (resync),
        .rx_done   (rx_done_i),
        .rx_data   (rx_data_i),
        .pkt_valid (pkt_valid_o),
        .dx        (dx_o),
        .dy        (dy_o),
        .btn       (btn_o)
    );

endmodule

// File: tb/tb_mouse_ctrl_sequencer.sv
// Randomized bench for mouse_ctrl_sequencer: a transaction-level device/transceiver
// model drives bring-up and streaming, and expected values come from protocol rules.
module tb_mouse_ctrl_sequencer;
    import mouse_pkg::*;

    localparam int unsigned TIMEOUT = 1000;
    localparam int unsigned RETRIES = 3;
    localparam logic [7:0]  RATE    = 8'd100;

    logic              clk_i = 1'b0;
    logic              reset_i, start_i, tx_done_i, rx_done_i;
    logic [7:0]        rx_data_i;
    logic              tx_en_o, stream_o, error_o, pkt_valid_o;
    logic [7:0]        tx_data_o;
    logic signed [8:0] dx_o, dy_o;
    logic [2:0]        btn_o, state_o;

    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         last_tx_cyc = 0;
    int         last_done_cyc = 0;
    int         exp_dx = 0;
    int         exp_dy = 0;
    int         exp_btn = 0;
    logic [7:0] cmds [4];

    mouse_ctrl_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES    (RETRIES),
        .SAMPLE_RATE    (RATE)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .tx_en_o     (tx_en_o),
        .tx_data_o   (tx_data_o),
        .tx_done_i   (tx_done_i),
        .rx_data_i   (rx_data_i),
        .rx_done_i   (rx_done_i),
        .stream_o    (stream_o),
        .error_o     (error_o),
        .pkt_valid_o (pkt_valid_o),
        .dx_o        (dx_o),
        .dy_o        (dy_o),
        .btn_o       (btn_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks below start and end at a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic rx_byte(input logic [7:0] b, output logic pv);
        rx_data_i = b;
        rx_done_i = 1'b1;
        @(negedge clk_i);
        pv        = pkt_valid_o;
        rx_done_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Transceiver model: wait for the strobe, check the byte, answer with tx_done.
    task automatic expect_tx(input string tag, input logic [7:0] exp, input int budget);
        int n = 0;
        while (tx_en_o !== 1'b1 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, " strobe"}, tx_en_o, 1);
        if (tx_en_o === 1'b1) begin
            last_tx_cyc = cyc;
            check({tag, " byte"}, tx_data_o, exp);
            @(negedge clk_i);
            check({tag, " strobe width"}, tx_en_o, 0);
            tick($urandom_range(0, 2));
            tx_done_i     = 1'b1;
            last_done_cyc = cyc;
            @(negedge clk_i);
            tx_done_i = 1'b0;
        end
    endtask

    // Device model for one bring-up attempt: ends in STREAM or ERROR.
    task automatic run_bringup(input bit faults, input int first_budget);
        int         pos = 0;
        int         fails = 0;
        int         budget = first_budget;
        int         r;
        bit         done = 0;
        bit         failed;
        logic       pv;
        logic [7:0] b;
        while (!done) begin
            expect_tx($sformatf("bringup cmd%0d", pos), cmds[pos], budget);
            budget = 20;
            tick($urandom_range(0, 5));
            r      = faults ? int'($urandom_range(0, 9)) : 0;
            failed = 0;
            if (r < 7) begin
                rx_byte(RSP_ACK, pv);
                if (pos == 0) begin
                    tick($urandom_range(0, 5));
                    if (!faults || $urandom_range(0, 3) != 0) begin
                        rx_byte(RSP_BAT_OK, pv);
                        tick($urandom_range(0, 5));
                        rx_byte(8'($urandom), pv);
                        pos = 1;
                    end else begin
                        b = ($urandom_range(0, 1) == 0) ? RSP_BAT_ERR : 8'($urandom);
                        if (b == RSP_BAT_OK) b = RSP_BAT_ERR;
                        rx_byte(b, pv);
                        failed = 1;
                    end
                end else if (pos == 3) begin
                    check("stream entered", stream_o, 1);
                    check("no error at stream", error_o, 0);
                    done = 1;
                end else begin
                    pos++;
                end
            end else if (r < 9) begin
                rx_byte(RSP_NAK, pv);
                failed = 1;
            end else begin
                b = 8'($urandom);
                if (b == RSP_ACK || b == RSP_NAK) b = 8'h00;
                rx_byte(b, pv);
                failed = 1;
                pos    = 0;
            end
            if (failed) begin
                if (fails == RETRIES) begin
                    check("error entered", error_o, 1);
                    check("no stream at error", stream_o, 0);
                    done = 1;
                end else begin
                    fails++;
                end
            end
        end
    endtask

    task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2);
        logic pv;
        rx_byte(b0, pv);
        check({tag, " pv byte0"}, pv, 0);
        tick($urandom_range(0, 4));
        rx_byte(b1, pv);
        check({tag, " pv byte1"}, pv, 0);
        tick($urandom_range(0, 4));
        rx_byte(b2, pv);
        check({tag, " pv byte2"}, pv, 1);
        exp_dx  = b0[6] ? 0 : int'(b1) - (b0[4] ? 256 : 0);
        exp_dy  = b0[7] ? 0 : int'(b2) - (b0[5] ? 256 : 0);
        exp_btn = int'(b0[2:0]);
        check({tag, " dx"}, dx_o, exp_dx);
        check({tag, " dy"}, dy_o, exp_dy);
        check({tag, " btn"}, btn_o, exp_btn);
        @(negedge clk_i);
        check({tag, " pv width"}, pkt_valid_o, 0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, " tx_en"}, tx_en_o, 0);
        check({tag, " tx_data"}, tx_data_o, 8'hFF);
        check({tag, " stream"}, stream_o, 0);
        check({tag, " error"}, error_o, 0);
        check({tag, " pkt_valid"}, pkt_valid_o, 0);
        check({tag, " dx"}, dx_o, 0);
        check({tag, " dy"}, dy_o, 0);
        check({tag, " btn"}, btn_o, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pv;
        int   prev_done;
        cmds      = '{8'hFF, 8'hF3, RATE, 8'hF4};
        reset_i   = 1'b1;
        start_i   = 1'b0;
        tx_done_i = 1'b0;
        rx_done_i = 1'b0;
        rx_data_i = 8'h00;
        tick(3);
        reset_values("reset");
        check("reset state", state_o, 0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);

        // Clean bring-up: the first strobe must be present in the first cycle.
        run_bringup(0, 0);

        // Directed and random packets.
        send_packet("pkt 19/05/FE", 8'h19, 8'h05, 8'hFE);
        check("pkt 19/05/FE dx bits", $unsigned(dx_o), 9'h105);
        rx_byte(8'h01, pv);
        check("unsynced byte pv", pv, 0);
        send_packet("pkt 58/10/20", 8'h58, 8'h10, 8'h20);
        for (int i = 0; i < 12; i++) begin
            tick($urandom_range(0, 20));
            send_packet($sformatf("rand pkt %0d", i), 8'($urandom) | 8'h08, 8'($urandom), 8'($urandom));
        end

        // Partial packet then a long gap: framing resyncs, no retry, outputs held.
        rx_byte(8'h08, pv);
        check("partial pv", pv, 0);
        tick(TIMEOUT + 20);
        check("resync still streaming", stream_o, 1);
        check("resync no error", error_o, 0);
        check("resync dx held", dx_o, exp_dx);
        send_packet("post-resync", 8'h09, 8'h03, 8'h04);

        // NAK to F3 resends F3 once; start_i is ignored while waiting.
        pulse_start();
        expect_tx("nak FF", 8'hFF, 5);
        rx_byte(RSP_ACK, pv);
        rx_byte(RSP_BAT_OK, pv);
        rx_byte(8'h00, pv);
        expect_tx("nak F3", 8'hF3, 5);
        pulse_start();
        check("start ignored in wait", tx_en_o, 0);
        rx_byte(RSP_NAK, pv);
        expect_tx("nak F3 resend", 8'hF3, 5);
        rx_byte(RSP_ACK, pv);
        expect_tx("nak rate", RATE, 5);
        rx_byte(RSP_ACK, pv);
        expect_tx("nak F4", 8'hF4, 5);
        rx_byte(RSP_ACK, pv);
        check("nak stream", stream_o, 1);
        check("nak no error", error_o, 0);

        // Four self-test failures in a row reach ERROR; start_i restarts with FF.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            expect_tx($sformatf("bat fail %0d", i), 8'hFF, 5);
            rx_byte(RSP_ACK, pv);
            rx_byte(RSP_BAT_ERR, pv);
            check($sformatf("error after bat fail %0d", i), error_o, (i == 3) ? 1 : 0);
        end
        pulse_start();
        run_bringup(0, 5);

        // Random bring-ups with NAKs, bad responses and self-test failures.
        for (int i = 0; i < 8; i++) begin
            pulse_start();
            run_bringup(1, 5);
        end

        // Silent device: timeout restarts, ERROR after the fourth expiry.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            prev_done = last_done_cyc;
            expect_tx($sformatf("timeout FF %0d", i), 8'hFF, (i == 0) ? 5 : int'(TIMEOUT) + 20);
            if (i > 0) check($sformatf("timeout spacing %0d", i), last_tx_cyc - prev_done, TIMEOUT + 1);
            check($sformatf("no error before expiry %0d", i), error_o, 0);
        end
        tick(TIMEOUT + 5);
        check("timeout error", error_o, 1);
        check("timeout no further tx", tx_en_o, 0);

        // Reset in the middle of a packet clears everything.
        pulse_start();
        run_bringup(0, 5);
        rx_byte(8'h08, pv);
        reset_i = 1'b1;
        #1;
        reset_values("mid reset");
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        run_bringup(0, 0);
        send_packet("after reset", 8'h28, 8'h07, 8'h09);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
